mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//   Word-addressed memory with a wait-state request/done handshake, fed by the Memory Address Register.
//   Receives the address directly from the MAR output and write data from the MDR/bus.
//   Captures the request, inserts programmable wait states, then performs one read or write.
//   Signals completion to the control unit with a one-cycle done pulse.
// PARAMETERS
//   ADDR_W    16   width of incoming address (MAR output width)
//   DATA_W    16   data word width
//   DEPTH     256  number of words; power of two, <= 2**ADDR_W; index AW = log2(DEPTH)
//   WAIT_CYC  2    wait states per access, legal 0..15
// PORTS
//   clk     in   1       system clock, all logic on rising edge
//   reset   in   1       synchronous, active-high reset
//   addr    in   ADDR_W  word address from MAR; sampled only when a request is accepted
//   wdata   in   DATA_W  write data; sampled with addr
//   rd_req  in   1       read request, level; accepted only in IDLE
//   wr_req  in   1       write request, level; accepted only in IDLE
//   rdata   out  DATA_W  read data; updated at read completion, held until the next read completes
//   busy    out  1       high while an access is in progress (WAIT state)
//   done    out  1       one-cycle pulse when the access completes
//   err     out  1       range-error pulse, concurrent with done (MEM_RANGE_CHK_EN only)
// BEHAVIOUR
//   Reset (sync, reset high at edge):
//     - state=IDLE; busy=0, done=0, rdata=0, err=0; wait counter=0.
//     - Memory array is NOT cleared.
//   FSM states: IDLE, WAIT, DONE.
//   IDLE:
//     - On an edge with rd_req|wr_req: latch addr[AW-1:0], wdata and op; load counter=WAIT_CYC; go WAIT.
//     - If rd_req and wr_req are both high, the op is WRITE and the read is dropped.
//   WAIT (busy=1):
//     - Each edge with counter!=0: counter decrements.
//     - Edge with counter==0: perform the access, go DONE.
//     - WRITE: mem[idx] <= latched wdata.
//     - READ: rdata <= mem[idx].
//   DONE (busy=0, done=1 for exactly one cycle): next edge goes to IDLE.
//     - A request is not accepted in DONE.
//   Timing:
//     - Request accepted at edge E; access occurs at edge E+WAIT_CYC+1; done high in the following cycle.
//     - Minimum request-to-request period: WAIT_CYC+3 cycles.
//     - WAIT_CYC=0: one WAIT cycle, then DONE.
//   Requests during WAIT/DONE are ignored, not queued. Requesters hold req until done, then drop it.
//     - A req still high in the IDLE cycle after DONE starts a new access.
//   addr/wdata changes after acceptance have no effect on the current access (latched copy used).
//   Reset mid-operation: access aborted, FSM to IDLE next cycle, no done pulse.
//     - Memory is modified only if the access edge already occurred before reset.
//   X/Z on addr (MAR reset value) is harmless unless a request is accepted.
// CONFIGURATION
//   MEM_RANGE_CHK_EN defined:
//     - At acceptance, if latched full addr >= DEPTH, the access is suppressed.
//     - WRITE: memory unchanged. READ: rdata <= 0.
//     - err=1 in the DONE cycle, otherwise 0.
//   MEM_RANGE_CHK_EN undefined:
//     - Upper address bits are ignored; addresses alias modulo DEPTH.
//     - err is tied 0.
// TESTING (DEPTH=256, WAIT_CYC=2, DATA_W=16)
//   1. Reset, then write addr=0x0010 wdata=0xBEEF -> busy high 3 cycles; done pulses 1 cycle;
//      subsequent read of 0x0010 -> rdata=0xBEEF with done.
//   2. rd_req accepted at edge E -> done high exactly after edge E+3; busy=0 and done=1 in that cycle;
//      rdata stable until the next read.
//   3. rd_req=wr_req=1, addr=0x0020, wdata=0x1234 -> write performed;
//      rdata unchanged; later read of 0x0020 returns 0x1234.
//   4. Change addr/wdata and toggle wr_req during WAIT -> original latched access only; no extra done.
//   5. reset asserted in the 2nd WAIT cycle of a write to 0x0030 ->
//      busy=0, done never pulses, mem[0x30] keeps its old value.
//   6. Write 0x5A5A to addr=0x0105:
//      - with MEM_RANGE_CHK_EN: err=1 with done, and mem[0x05] unchanged;
//      - without MEM_RANGE_CHK_EN: mem[0x05]=0x5A5A and err=0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Word-addressed memory behind a request/done handshake with programmable wait states.
// A request is latched in IDLE, held for WAIT_CYC+1 cycles in WAIT, then one read or write
// is performed and done pulses for a single cycle.
// Optional feature macro: MEM_RANGE_CHK_EN
//   When defined, any address at or above DEPTH suppresses the access and raises err with done.
//   When undefined, the upper address bits are ignored and err stays 0.
module mem_access_unit #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_req,
    input  logic              wr_req,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [3:0] WaitLoad = 4'(WAIT_CYC);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StDone
    } state_e;

    state_e            state;
    logic [3:0]        cnt;
    logic [AW-1:0]     idx;
    logic [DATA_W-1:0] wdata_lat;
    logic              op_wr;
    logic              oor;
    logic              oor_next;
    logic              access_now;
    logic              mem_we;

    logic [DATA_W-1:0] mem [DEPTH];

`ifdef MEM_RANGE_CHK_EN
    // Any set bit above the index width means the address lies outside the array.
    assign oor_next = |(addr >> AW);
`else
    // Upper bits are ignored; addresses alias modulo DEPTH.
    assign oor_next = 1'b0;
    logic unused_addr;
    assign unused_addr = |(addr >> AW);
`endif

    assign access_now = (state == StWait) && (cnt == 4'd0);
    // A reset on the access edge aborts the write as well.
    assign mem_we     = access_now && op_wr && !oor && !reset;

    // Memory array: write port only, never cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_lat;
        end
    end

    // Control FSM with registered busy/done/err/rdata outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            cnt   <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
            oor   <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (rd_req || wr_req) begin
                        idx       <= addr[AW-1:0];
                        wdata_lat <= wdata;
                        // Write wins when both requests are raised together.
                        op_wr     <= wr_req;
                        oor       <= oor_next;
                        cnt       <= WaitLoad;
                        busy      <= 1'b1;
                        state     <= StWait;
                    end
                end
                StWait: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!op_wr) begin
                            rdata <= oor ? '0 : mem[idx];
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        err   <= oor;
                        state <= StDone;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (DEPTH=256, WAIT_CYC=2, DATA_W=16).
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rd_req;
    logic        wr_req;
    logic [15:0] rdata;
    logic        busy;
    logic        done;
    logic        err;

    int checks;
    int failures;

    mem_access_unit #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .DEPTH   (256),
        .WAIT_CYC(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .wdata (wdata),
        .rd_req(rd_req),
        .wr_req(wr_req),
        .rdata (rdata),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete handshake from an IDLE negedge; requests dropped once done is seen.
    task automatic access(input logic wr, input logic rd, input logic [15:0] a,
                          input logic [15:0] d, output int lat, output int nbusy,
                          output logic seen, output logic [15:0] rd_at, output logic err_at,
                          output logic busy_at);
        addr   = a;
        wdata  = d;
        wr_req = wr;
        rd_req = rd;
        lat    = 0;
        nbusy  = 0;
        seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (busy === 1'b1) nbusy++;
        end
        rd_at   = rdata;
        err_at  = err;
        busy_at = busy;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        @(negedge clk);
        check("done_one_cycle", {15'd0, done}, 16'd0);
    endtask

    int          lat;
    int          nbusy;
    logic        seen;
    logic [15:0] rd_at;
    logic        err_at;
    logic        busy_at;
    int          ndone;

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        addr     = 16'hxxxx;
        wdata    = 16'h0000;
        rd_req   = 1'b0;
        wr_req   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_err", {15'd0, err}, 16'd0);
        check("reset_rdata", rdata, 16'h0000);
        reset = 1'b0;
        @(negedge clk);
        check("idle_x_addr_busy", {15'd0, busy}, 16'd0);

        // 1: write then read back 0x0010
        access(1'b1, 1'b0, 16'h0010, 16'hBEEF, lat, nbusy, seen, rd_at, err_at, busy_at);
        check("t1_wr_done_seen", {15'd0, seen}, 16'd1);
        check("t1_wr_busy_cycles", 16'(nbusy), 16'd3);
        check("t1_wr_latency", 16'(lat), 16'd4);
        check("t1_wr_busy_at_done", {15'd0, busy_at}, 16'd0);
        access(1'b0, 1'b1, 16'h0010, 16'h0000, lat, nbusy, seen, rd_at, err_at, busy_at);
        check("t1_rd_data", rd_at, 16'hBEEF);

        // 2: read latency and rdata hold
        check("t2_rd_latency", 16'(lat), 16'd4);
        check("t2_rd_busy_at_done", {15'd0, busy_at}, 16'd0);
        repeat (3) @(negedge clk);
        check("t2_rdata_hold", rdata, 16'hBEEF);

        // 3: simultaneous rd/wr behaves as write
        access(1'b1, 1'b1, 16'h0020, 16'h1234, lat, nbusy, seen, rd_at, err_at, busy_at);
        check("t3_both_done", {15'd0, seen}, 16'd1);
        check("t3_rdata_unchanged", rd_at, 16'hBEEF);
        access(1'b0, 1'b1, 16'h0020, 16'h0000, lat, nbusy, seen, rd_at, err_at, busy_at);
        check("t3_readback", rd_at, 16'h1234);

        // 4: input changes during WAIT do not affect the latched access
        access(1'b1, 1'b0, 16'h0041, 16'h1111, lat, nbusy, seen, rd_at, err_at, busy_at);
        addr   = 16'h0040;
        wdata  = 16'hAAAA;
        wr_req = 1'b1;
        @(negedge clk);
        check("t4_busy", {15'd0, busy}, 16'd1);
        addr   = 16'h0041;
        wdata  = 16'h5555;
        wr_req = 1'b0;
        @(negedge clk);
        wr_req = 1'b1;
        @(negedge clk);
        wr_req = 1'b0;
        @(negedge clk);
        check("t4_done", {15'd0, done}, 16'd1);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("t4_no_extra_done", 16'(ndone), 16'd0);
        access(1'b0, 1'b1, 16'h0040, 16'h0000, lat, nbusy, seen, rd_at, err_at, busy_at);
        check("t4_rd_0x40", rd_at, 16'hAAAA);
        access(1'b0, 1'b1, 16'h0041, 16'h0000, lat, nbusy, seen, rd_at, err_at, busy_at);
        check("t4_rd_0x41", rd_at, 16'h1111);

        // 5: reset in the second WAIT cycle aborts a write
        access(1'b1, 1'b0, 16'h0030, 16'h7777, lat, nbusy, seen, rd_at, err_at, busy_at);
        addr   = 16'h0030;
        wdata  = 16'hDEAD;
        wr_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t5_busy_before_reset", {15'd0, busy}, 16'd1);
        reset  = 1'b1;
        wr_req = 1'b0;
        @(negedge clk);
        check("t5_busy_after_reset", {15'd0, busy}, 16'd0);
        check("t5_rdata_after_reset", rdata, 16'h0000);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        check("t5_no_done", 16'(ndone), 16'd0);
        access(1'b0, 1'b1, 16'h0030, 16'h0000, lat, nbusy, seen, rd_at, err_at, busy_at);
        check("t5_mem_kept", rd_at, 16'h7777);

        // 6: out-of-range address 0x0105
        access(1'b1, 1'b0, 16'h0005, 16'h0505, lat, nbusy, seen, rd_at, err_at, busy_at);
        check("t6_inrange_err", {15'd0, err_at}, 16'd0);
        access(1'b1, 1'b0, 16'h0105, 16'h5A5A, lat, nbusy, seen, rd_at, err_at, busy_at);
`ifdef MEM_RANGE_CHK_EN
        check("t6_wr_err", {15'd0, err_at}, 16'd1);
        access(1'b0, 1'b1, 16'h0105, 16'h0000, lat, nbusy, seen, rd_at, err_at, busy_at);
        check("t6_rd_oor_err", {15'd0, err_at}, 16'd1);
        check("t6_rd_oor_data", rd_at, 16'h0000);
        access(1'b0, 1'b1, 16'h0005, 16'h0000, lat, nbusy, seen, rd_at, err_at, busy_at);
        check("t6_mem5", rd_at, 16'h0505);
`else
        check("t6_wr_err", {15'd0, err_at}, 16'd0);
        access(1'b0, 1'b1, 16'h0005, 16'h0000, lat, nbusy, seen, rd_at, err_at, busy_at);
        check("t6_mem5", rd_at, 16'h5A5A);
        check("t6_rd_err", {15'd0, err_at}, 16'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
